// File: rtl/line_win_ctrl_pkg.sv
// Shared types and defaults for the line window controller.
// FSM state, per-state FIFO enable set and default frame geometry.
package line_win_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;

   typedef enum logic [2:0] {
      IDLE,
      FILL0,
      FILL1,
      RUN,
      FLUSH,
      DONE
   } state_t;

   typedef struct packed {
      logic a_wr;
      logic a_rd;
      logic b_rd;
   } fifo_en_t;

   // FIFO enables that one pixel slot produces in a given line-fill state.
   function automatic fifo_en_t en_for_state(input state_t s);
      fifo_en_t e;
      e = '0;
      case (s)
         FILL0: e.a_wr = 1'b1;
         FILL1: begin
            e.a_wr = 1'b1;
            e.a_rd = 1'b1;
         end
         RUN: begin
            e.a_wr = 1'b1;
            e.a_rd = 1'b1;
            e.b_rd = 1'b1;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/line_win_ctrl_if.sv
// Pixel-in / window-column-out bundle for line_win_ctrl.
// LINE_WIN_CTRL_COORD_EN adds the win_x/win_y coordinate signals.
interface line_win_ctrl_if
   import line_win_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
);
   // Valid-only streams, no ready: a pixel counts in every cycle pix_vld is
   // high, and col_vld is high for exactly one cycle per window column.
   logic                  frame_start;
   logic                  pix_vld;
   logic [DATA_WIDTH-1:0] pix_data;
   logic                  col_vld;
   logic [DATA_WIDTH-1:0] win_top;
   logic [DATA_WIDTH-1:0] win_mid;
   logic [DATA_WIDTH-1:0] win_bot;
   logic                  busy;
   logic                  drop;
`ifdef LINE_WIN_CTRL_COORD_EN
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   logic [CW-1:0]         win_x;
   logic [RW-1:0]         win_y;
`endif

   modport master (
      output frame_start, pix_vld, pix_data,
`ifdef LINE_WIN_CTRL_COORD_EN
      input  win_x, win_y,
`endif
      input  col_vld, win_top, win_mid, win_bot, busy, drop
   );

   modport slave (
      input  frame_start, pix_vld, pix_data,
`ifdef LINE_WIN_CTRL_COORD_EN
      output win_x, win_y,
`endif
      output col_vld, win_top, win_mid, win_bot, busy, drop
   );

endinterface

// File: rtl/line_win_ctrl_fifo_ram.sv
// One-line FIFO: circular RAM with free-running pointers and registered
// read-first output. No reset, so contents and pointers survive rst_n.
module fifo_ram #(
   parameter int DATA_DEPTH = 640,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DATA_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      if (wr_en) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
         rd_data_d = mem[rd_ptr_q];
      end
   end

   // A same-address read and write in one cycle returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= wr_data;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/line_win_ctrl.sv
// line_win_ctrl: row/column sequencer feeding a 3-row column from two cascaded
// line FIFOs. Optional LINE_WIN_CTRL_COORD_EN adds win_x/win_y outputs.
module line_win_ctrl
   import line_win_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input  logic           clk,
   input  logic           rst_n,
   line_win_ctrl_if.slave io,
   output state_t         dbg_state
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   state_t                state_q, state_d;
   state_t                abort_q, abort_d;
   logic [CW-1:0]         col_cnt_q, col_cnt_d;
   logic [RW-1:0]         row_cnt_q, row_cnt_d;
   logic                  drop_q, drop_d;
   logic                  col_vld_q, col_vld_d;
   logic [DATA_WIDTH-1:0] win_bot_q, win_bot_d;
   logic                  b_wr_q, b_wr_d;
   fifo_en_t              en;
   logic                  step;
   logic [DATA_WIDTH-1:0] a_wr_data;
   logic [DATA_WIDTH-1:0] a_rd_data;
   logic [DATA_WIDTH-1:0] b_rd_data;
`ifdef LINE_WIN_CTRL_COORD_EN
   logic [CW-1:0]         win_x_q, win_x_d;
   logic [RW-1:0]         win_y_q, win_y_d;
`endif

   always_comb begin
      state_d   = state_q;
      abort_d   = abort_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      drop_d    = drop_q;
      col_vld_d = 1'b0;
      win_bot_d = win_bot_q;
      en        = '0;
      step      = 1'b0;
      a_wr_data = '0;
`ifdef LINE_WIN_CTRL_COORD_EN
      win_x_d   = win_x_q;
      win_y_d   = win_y_q;
`endif
      if (io.frame_start) begin
         // A pixel coinciding with frame_start is discarded.
         drop_d = io.pix_vld;
         if (col_cnt_q == '0) begin
            state_d   = FILL0;
            row_cnt_d = '0;
         end else begin
            state_d = FLUSH;
            if (state_q != FLUSH) begin
               abort_d = state_q;
            end
         end
      end else begin
         unique case (state_q)
            FILL0, FILL1, RUN: begin
               if (io.pix_vld) begin
                  step      = 1'b1;
                  en        = en_for_state(state_q);
                  a_wr_data = io.pix_data;
                  win_bot_d = io.pix_data;
                  col_vld_d = (state_q == RUN);
`ifdef LINE_WIN_CTRL_COORD_EN
                  if (state_q == RUN) begin
                     win_x_d = col_cnt_q;
                     win_y_d = row_cnt_q;
                  end
`endif
               end
            end
            FLUSH: begin
               // Replay the aborted line's enables with zero data so both
               // FIFOs end the line with paired pointers.
               step = 1'b1;
               en   = en_for_state(abort_q);
               if (io.pix_vld) begin
                  drop_d = 1'b1;
               end
            end
            default: step = 1'b0;
         endcase

         if (step) begin
            if (col_cnt_q == COL_LAST) begin
               col_cnt_d = '0;
               row_cnt_d = row_cnt_q + RW'(1);
               case (state_q)
                  FILL0: state_d = FILL1;
                  FILL1: state_d = RUN;
                  RUN: begin
                     if (row_cnt_q == ROW_LAST) begin
                        state_d   = DONE;
                        row_cnt_d = '0;
                     end
                  end
                  FLUSH: begin
                     state_d   = FILL0;
                     row_cnt_d = '0;
                  end
                  default: state_d = state_q;
               endcase
            end else begin
               col_cnt_d = col_cnt_q + CW'(1);
            end
         end
      end
      b_wr_d = en.a_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         abort_q   <= IDLE;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         drop_q    <= 1'b0;
         col_vld_q <= 1'b0;
         win_bot_q <= '0;
`ifdef LINE_WIN_CTRL_COORD_EN
         win_x_q   <= '0;
         win_y_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         abort_q   <= abort_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         drop_q    <= drop_d;
         col_vld_q <= col_vld_d;
         win_bot_q <= win_bot_d;
`ifdef LINE_WIN_CTRL_COORD_EN
         win_x_q   <= win_x_d;
         win_y_q   <= win_y_d;
`endif
      end
   end

   // Belongs to the FIFO side: an in-flight B write must still land across
   // rst_n or B's pointers would slip by one.
   always_ff @(posedge clk) begin
      b_wr_q <= b_wr_d;
   end

   fifo_ram #(.DATA_DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_a (
      .clk     (clk),
      .wr_en   (en.a_wr),
      .wr_data (a_wr_data),
      .rd_en   (en.a_rd),
      .rd_data (a_rd_data)
   );

   fifo_ram #(.DATA_DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_b (
      .clk     (clk),
      .wr_en   (b_wr_q),
      .wr_data (a_rd_data),
      .rd_en   (en.b_rd),
      .rd_data (b_rd_data)
   );

   // FIFO output registers have no reset, so the upper rows are gated.
   assign io.col_vld = col_vld_q;
   assign io.win_top = col_vld_q ? b_rd_data : '0;
   assign io.win_mid = col_vld_q ? a_rd_data : '0;
   assign io.win_bot = win_bot_q;
   assign io.busy    = (state_q == FILL0) || (state_q == FILL1) ||
                       (state_q == RUN)   || (state_q == FLUSH);
   assign io.drop    = drop_q;
`ifdef LINE_WIN_CTRL_COORD_EN
   assign io.win_x   = win_x_q;
   assign io.win_y   = win_y_q;
`endif
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_win_ctrl.sv
// Bench for line_win_ctrl on an 8x4 frame: table of frame variants plus
// hand-written abort/FLUSH, coincident frame_start and mid-RUN reset sequences.
module tb_line_win_ctrl;
   import line_win_pkg::*;

   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);
   localparam int EW = RW + CW + 3 * DW;

   typedef struct {
      int gap_mode;
      bit fs_with_pix;
      int exp_pulses;
      bit exp_drop;
   } frame_vec_t;

   typedef struct {
      int            r;
      int            c;
      logic [DW-1:0] top;
      logic [DW-1:0] mid;
      logic [DW-1:0] bot;
   } spot_t;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;
   int     checks     = 0;
   int     errors     = 0;
   int     col_pulses = 0;
   logic [EW-1:0] exp_q[$];
   frame_vec_t frame_tab[4];
   spot_t      spot_tab[4];

   line_win_ctrl_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) io ();

   line_win_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .io        (io),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return DW'(r * 16 + c);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, sample outputs at the following negedge.
   task automatic cycle(input bit fs, input bit vld, input logic [DW-1:0] data, input bit exp_vld);
      logic [EW-1:0] e;
      int ex, ey;
      io.frame_start = fs;
      io.pix_vld     = vld;
      io.pix_data    = data;
      @(posedge clk);
      @(negedge clk);
      chk("col_vld", 32'(io.col_vld), 32'(exp_vld));
      if (io.col_vld) begin
         col_pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL win_pop: got col_vld=1 required no column");
         end else begin
            e  = exp_q.pop_front();
            ex = int'(e[3*DW +: CW]);
            ey = int'(e[3*DW+CW +: RW]);
            chk("win_bot", 32'(io.win_bot), 32'(e[DW-1:0]));
            chk("win_mid", 32'(io.win_mid), 32'(e[2*DW-1:DW]));
            chk("win_top", 32'(io.win_top), 32'(e[3*DW-1:2*DW]));
`ifdef LINE_WIN_CTRL_COORD_EN
            chk("win_x", 32'(io.win_x), 32'(ex));
            chk("win_y", 32'(io.win_y), 32'(ey));
`endif
            foreach (spot_tab[i]) begin
               if (spot_tab[i].r == ey && spot_tab[i].c == ex) begin
                  chk("spot_top", 32'(io.win_top), 32'(spot_tab[i].top));
                  chk("spot_mid", 32'(io.win_mid), 32'(spot_tab[i].mid));
                  chk("spot_bot", 32'(io.win_bot), 32'(spot_tab[i].bot));
               end
            end
         end
      end
   endtask

   task automatic drive_pix(input int r, input int c);
      if (r >= 2) begin
         exp_q.push_back({RW'(r), CW'(c), pix(r - 2, c), pix(r - 1, c), pix(r, c)});
      end
      cycle(1'b0, 1'b1, pix(r, c), r >= 2);
   endtask

   task automatic run_frame(input int gap_mode, input bit fs_with_pix);
      exp_q.delete();
      col_pulses = 0;
      if (fs_with_pix) begin
         cycle(1'b1, 1'b1, 8'hEE, 1'b0);
         chk("drop_on_fs_pix", 32'(io.drop), 32'd1);
      end else begin
         cycle(1'b1, 1'b0, 8'h00, 1'b0);
         chk("drop_clear", 32'(io.drop), 32'd0);
      end
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            drive_pix(r, c);
            if (r == 0 && c == 0) chk("busy_on", 32'(io.busy), 32'd1);
            if (gap_mode == 1) begin
               cycle(1'b0, 1'b0, 8'h00, 1'b0);
            end else if (gap_mode == 2) begin
               for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                  cycle(1'b0, 1'b0, 8'h00, 1'b0);
               end
            end
         end
      end
   endtask

   initial begin
      int flush_cycles;
      frame_tab[0] = '{gap_mode: 0, fs_with_pix: 1'b0, exp_pulses: 16, exp_drop: 1'b0};
      frame_tab[1] = '{gap_mode: 1, fs_with_pix: 1'b0, exp_pulses: 16, exp_drop: 1'b0};
      frame_tab[2] = '{gap_mode: 2, fs_with_pix: 1'b0, exp_pulses: 16, exp_drop: 1'b0};
      frame_tab[3] = '{gap_mode: 0, fs_with_pix: 1'b1, exp_pulses: 16, exp_drop: 1'b1};
      spot_tab[0] = '{r: 2, c: 3, top: 8'h03, mid: 8'h13, bot: 8'h23};
      spot_tab[1] = '{r: 2, c: 0, top: 8'h00, mid: 8'h10, bot: 8'h20};
      spot_tab[2] = '{r: 3, c: 7, top: 8'h17, mid: 8'h27, bot: 8'h37};
      spot_tab[3] = '{r: 3, c: 4, top: 8'h14, mid: 8'h24, bot: 8'h34};

      io.frame_start = 1'b0;
      io.pix_vld     = 1'b0;
      io.pix_data    = '0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_col_vld", 32'(io.col_vld), 32'd0);
      chk("rst_win_bot", 32'(io.win_bot), 32'd0);
      chk("rst_win_mid", 32'(io.win_mid), 32'd0);
      chk("rst_win_top", 32'(io.win_top), 32'd0);
      chk("rst_busy", 32'(io.busy), 32'd0);
      chk("rst_drop", 32'(io.drop), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      cycle(1'b0, 1'b1, 8'h77, 1'b0);
      chk("idle_no_drop", 32'(io.drop), 32'd0);

      for (int i = 0; i < 4; i++) begin
         run_frame(frame_tab[i].gap_mode, frame_tab[i].fs_with_pix);
         chk("pulses", 32'(col_pulses), 32'(frame_tab[i].exp_pulses));
         chk("busy_done", 32'(io.busy), 32'd0);
         chk("state_done", 32'(dbg_state), 32'(DONE));
         chk("drop_end", 32'(io.drop), 32'(frame_tab[i].exp_drop));
         chk("queue_empty", 32'(exp_q.size()), 32'd0);
      end
      cycle(1'b0, 1'b1, 8'h66, 1'b0);
      chk("done_no_extra", 32'(io.busy), 32'd0);

      // Abort at row 1, col 3: FLUSH pads the remaining 5 columns.
      exp_q.delete();
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < W + 3; k++) drive_pix(k / W, k % W);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("flush_enter", 32'(dbg_state), 32'(FLUSH));
      chk("flush_busy", 32'(io.busy), 32'd1);
      flush_cycles = 1;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, i == 1, 8'h55, 1'b0);
         if (dbg_state != FLUSH) break;
         flush_cycles++;
      end
      chk("flush_len", 32'(flush_cycles), 32'd5);
      chk("flush_exit", 32'(dbg_state), 32'(FILL0));
      chk("flush_drop", 32'(io.drop), 32'd1);
      run_frame(0, 1'b0);
      chk("abort_pulses", 32'(col_pulses), 32'd16);
      chk("abort_queue", 32'(exp_q.size()), 32'd0);

      // Reset asserted in the middle of row 2.
      exp_q.delete();
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 2 * W + 5; k++) drive_pix(k / W, k % W);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_col_vld", 32'(io.col_vld), 32'd0);
      chk("mrst_win_bot", 32'(io.win_bot), 32'd0);
      chk("mrst_win_mid", 32'(io.win_mid), 32'd0);
      chk("mrst_win_top", 32'(io.win_top), 32'd0);
      chk("mrst_busy", 32'(io.busy), 32'd0);
      chk("mrst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(2, 1'b0);
      chk("mrst_pulses", 32'(col_pulses), 32'd16);
      chk("mrst_queue", 32'(exp_q.size()), 32'd0);
      chk("mrst_busy_done", 32'(io.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
